irq_ctrl: RTL and testbench



---
 rtl/irq_ctrl.sv | 145 ++++++++++++++
 tb/tb_irq_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Prioritised interrupt controller in front of the RISC5 irq input: synchronised
// edge/level requests, enable mask, in-service nesting and a 4-word register file.
module irq_ctrl #(
    parameter int                 NUM_IRQ     = 8,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK   = '1,
    parameter int                 SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               int_ack,
    input  logic               rti,
    input  logic               int_abort,
    output logic               irq,
    input  logic               wr,
    input  logic               rd,
    input  logic [1:0]         addr,
    input  logic [31:0]        din,
    output logic [31:0]        dout
);

    // Lowest set index wins; an all-zero vector yields 0 (callers qualify it).
    function automatic logic [4:0] lowest_idx(input logic [NUM_IRQ-1:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (v[i]) idx = 5'(i);
        return idx;
    endfunction

    function automatic logic [NUM_IRQ-1:0] onehot(input logic [4:0] idx);
        logic [NUM_IRQ-1:0] m;
        for (int i = 0; i < NUM_IRQ; i++)
            m[i] = (int'(idx) == i);
        return m;
    endfunction

    // Channels that outrank the current in-service level; idle is outranked by all.
    function automatic logic [NUM_IRQ-1:0] above(input logic [NUM_IRQ-1:0] ins);
        logic [NUM_IRQ-1:0] m;
        logic [4:0]         c;
        c = lowest_idx(ins);
        for (int i = 0; i < NUM_IRQ; i++)
            m[i] = (ins == '0) || (i < int'(c));
        return m;
    endfunction

    function automatic logic [31:0] ext32(input logic [NUM_IRQ-1:0] v);
        logic [31:0] r;
        r = '0;
        r[NUM_IRQ-1:0] = v;
        return r;
    endfunction

    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_p0;
    logic [NUM_IRQ-1:0] lvl_p1;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] inserv;
    logic [NUM_IRQ-1:0] enable;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] pend_view;
    logic [NUM_IRQ-1:0] elig;
    logic [NUM_IRQ-1:0] ins_rti;
    logic [NUM_IRQ-1:0] elig_ack;
    logic [NUM_IRQ-1:0] win_oh;
    logic [NUM_IRQ-1:0] ins_next;
    logic [NUM_IRQ-1:0] pend_next;
    logic [4:0]         cur;
    logic               req;
    logic               grant;
    logic [31:0]        rdata;
    logic               din_unused;

    assign din_unused = ^din;

    // Stage 0: synchroniser chain on the asynchronous request lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
        end else begin
            sync_p0[0] <= irq_in;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_p0[i] <= sync_p0[i-1];
        end
    end

    // Stage 1: previous synchronised level, used for edge detection and level requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lvl_p1 <= '0;
        else     lvl_p1 <= sync_p0[SYNC_STAGES-1];
    end

    assign rise      = sync_p0[SYNC_STAGES-1] & ~lvl_p1 & EDGE_MASK;
    assign pend_view = (pend & EDGE_MASK) | (lvl_p1 & ~EDGE_MASK);

    always_comb begin
        cur      = lowest_idx(inserv);
        elig     = pend_view & enable & above(inserv);
        req      = (elig != '0);

        // A same-cycle return is retired before the acknowledge picks its winner.
        ins_rti  = inserv;
        if (rti) ins_rti = inserv & ~onehot(cur);
        elig_ack = pend_view & enable & above(ins_rti);
        grant    = int_ack && (elig_ack != '0);
        win_oh   = onehot(lowest_idx(elig_ack));

        ins_next  = int_abort ? '0 : ins_rti;
        pend_next = pend;
        if (wr && addr == 2'd1) pend_next = pend_next | din[NUM_IRQ-1:0];
        if (wr && addr == 2'd2) pend_next = pend_next & ~din[NUM_IRQ-1:0];
        if (grant) begin
            ins_next  = ins_next | win_oh;
            pend_next = pend_next & ~win_oh;
        end
        // A fresh hardware edge always survives a clear in the same cycle.
        pend_next = (pend_next | rise) & EDGE_MASK;

        case (addr)
            2'd0:    rdata = ext32(enable);
            2'd1:    rdata = ext32(pend_view);
            2'd2:    rdata = ext32(inserv);
            default: rdata = {(inserv != '0), 26'd0, cur};
        endcase
    end

    // Stage 2: architectural state, irq output and registered read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend   <= '0;
            inserv <= '0;
            enable <= '0;
            irq    <= 1'b0;
            dout   <= '0;
        end else begin
            pend   <= pend_next;
            inserv <= ins_next;
            if (wr && addr == 2'd0) enable <= din[NUM_IRQ-1:0];
            irq    <= (int_ack || rti) ? 1'b0 : req;
            if (rd) dout <= rdata;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: vector table, directed multi-cycle sequences and randomised
// traffic compared every cycle against a behavioural model.
module tb_irq_ctrl;

    localparam int         N  = 8;
    localparam int         S  = 2;
    localparam logic [7:0] EM = 8'hFE;

    logic        clk, rst, int_ack, rti, int_abort, irq, wr, rd;
    logic [7:0]  irq_in;
    logic [1:0]  addr;
    logic [31:0] din, dout;

    irq_ctrl #(.NUM_IRQ(N), .EDGE_MASK(EM), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .int_ack(int_ack), .rti(rti),
        .int_abort(int_abort), .irq(irq), .wr(wr), .rd(rd), .addr(addr),
        .din(din), .dout(dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: edge-pending set, enable, in-service set, input history.
    logic [7:0]  m_pend = '0, m_en = '0, m_ins = '0;
    logic        m_irq = 1'b0;
    logic [31:0] m_dout = '0;
    logic [7:0]  m_hist [0:S];

    function automatic int lowest(input logic [7:0] v);
        for (int k = 0; k < N; k++) if (v[k]) return k;
        return N;
    endfunction

    function automatic int pick(input logic [7:0] p, input logic [7:0] en, input logic [7:0] ins);
        int lim = lowest(ins);
        for (int k = 0; k < lim; k++) if (p[k] && en[k]) return k;
        return -1;
    endfunction

    task automatic model_step();
        logic [7:0] lvl, rise, view, ins2, np;
        int c, w0, w;
        if (rst) begin
            m_pend = '0; m_en = '0; m_ins = '0; m_irq = 1'b0; m_dout = '0;
            for (int i = 0; i <= S; i++) m_hist[i] = '0;
            return;
        end
        lvl  = m_hist[S] & ~EM;
        rise = m_hist[S-1] & ~m_hist[S] & EM;
        view = m_pend | lvl;
        c    = lowest(m_ins);
        w0   = pick(view, m_en, m_ins);
        if (rd) begin
            case (addr)
                2'd0: m_dout = {24'd0, m_en};
                2'd1: m_dout = {24'd0, view};
                2'd2: m_dout = {24'd0, m_ins};
                default: m_dout = (c < N) ? {1'b1, 26'd0, 5'(c)} : 32'd0;
            endcase
        end
        ins2 = m_ins;
        if (rti && c < N) ins2[c] = 1'b0;
        w  = pick(view, m_en, ins2);
        np = m_pend;
        if (wr && addr == 2'd1) np = np | din[7:0];
        if (wr && addr == 2'd2) np = np & ~din[7:0];
        if (int_ack && w >= 0) np[w] = 1'b0;
        np = (np | rise) & EM;
        if (int_abort) ins2 = '0;
        if (int_ack && w >= 0) ins2[w] = 1'b1;
        if (wr && addr == 2'd0) m_en = din[7:0];
        m_irq  = (int_ack || rti) ? 1'b0 : (w0 >= 0);
        m_pend = np;
        m_ins  = ins2;
        for (int i = S; i >= 1; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = irq_in;
    endtask

    initial begin
        for (int i = 0; i <= S; i++) m_hist[i] = '0;
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("model_irq", {31'd0, irq}, {31'd0, m_irq});
            check("model_dout", dout, m_dout);
        end
    end

    task automatic step(input logic w, input logic r, input logic [1:0] a, input logic [31:0] d,
                        input logic ak, input logic rt, input logic ab);
        wr = w; rd = r; addr = a; din = d; int_ack = ak; rti = rt; int_abort = ab;
        @(posedge clk); #1;
        wr = 0; rd = 0; int_ack = 0; rti = 0; int_abort = 0;
    endtask

    task automatic wreg(input logic [1:0] a, input logic [31:0] d);
        step(1, 0, a, d, 0, 0, 0);
    endtask

    task automatic rchk(input logic [1:0] a, input logic [31:0] exp, input string nm);
        step(0, 1, a, 32'd0, 0, 0, 0);
        check(nm, dout, exp);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 2'd0, 32'd0, 0, 0, 0);
    endtask

    task automatic irq_is(input logic exp, input string nm);
        check(nm, {31'd0, irq}, {31'd0, exp});
    endtask

    typedef struct {
        logic        w, r;
        logic [1:0]  a;
        logic [31:0] d;
        logic [7:0]  lines;
        logic        ak, rt, chk_dout, e_irq;
        logic [31:0] e_dout;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic r, input logic [1:0] a,
                                input logic [31:0] d, input logic [7:0] lines,
                                input logic ak, input logic rt, input logic cd,
                                input logic ei, input logic [31:0] ed);
        vec_t v;
        v.w = w; v.r = r; v.a = a; v.d = d; v.lines = lines; v.ak = ak; v.rt = rt;
        v.chk_dout = cd; v.e_irq = ei; v.e_dout = ed;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        rst = 1; wr = 0; rd = 0; addr = 0; din = 0; irq_in = 0;
        int_ack = 0; rti = 0; int_abort = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        irq_is(1'b0, "reset_irq");
        check("reset_dout", dout, 32'd0);
        mon_en = 1;

        // Edge grant on channel 3, then software raise/clear under the enable mask.
        tbl.push_back(mk(1, 0, 2'd0, 32'hFF, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2'd0, 0, 8'h08, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2'd0, 0, 8'h08, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2'd0, 0, 8'h08, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'd1, 0, 8'h08, 0, 0, 1, 1, 32'h08));
        tbl.push_back(mk(0, 0, 2'd0, 0, 8'h00, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'd2, 0, 8'h00, 0, 0, 1, 0, 32'h08));
        tbl.push_back(mk(0, 1, 2'd1, 0, 8'h00, 0, 0, 1, 0, 32'h00));
        tbl.push_back(mk(0, 0, 2'd0, 0, 8'h00, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'd2, 0, 8'h00, 0, 0, 1, 0, 32'h00));
        tbl.push_back(mk(1, 0, 2'd0, 32'h00, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 2'd1, 32'h10, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'd1, 0, 8'h00, 0, 0, 1, 0, 32'h10));
        tbl.push_back(mk(1, 0, 2'd0, 32'h10, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'd0, 0, 8'h00, 0, 0, 1, 1, 32'h10));
        tbl.push_back(mk(1, 0, 2'd2, 32'h10, 8'h00, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 2'd1, 0, 8'h00, 0, 0, 1, 0, 32'h00));
        tbl.push_back(mk(0, 1, 2'd3, 0, 8'h00, 0, 0, 1, 0, 32'h00));
        tbl.push_back(mk(1, 0, 2'd3, 32'hFFFFFFFF, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'd3, 0, 8'h00, 0, 0, 1, 0, 32'h00));
        tbl.push_back(mk(1, 0, 2'd0, 32'hFFFFFFFF, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'd0, 0, 8'h00, 0, 0, 1, 0, 32'hFF));
        tbl.push_back(mk(1, 0, 2'd0, 32'h00, 8'h00, 0, 0, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            irq_in = tbl[i].lines;
            step(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].ak, tbl[i].rt, 0);
            check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, tbl[i].e_irq});
            if (tbl[i].chk_dout) check($sformatf("vec%0d_dout", i), dout, tbl[i].e_dout);
        end

        // Nesting: channel 5 in service, lower channel 6 blocked, higher channel 1 nests.
        wreg(2'd0, 32'hFF);
        wreg(2'd1, 32'h20);
        step(0, 0, 2'd0, 0, 1, 0, 0);
        irq_is(1'b0, "nest_ack5_irq");
        irq_in = 8'h40;
        for (int i = 0; i < 4; i++) begin
            ticks(1);
            irq_is(1'b0, "nest_ch6_blocked");
        end
        irq_in = 8'h42;
        ticks(3);
        irq_is(1'b0, "nest_ch1_latency");
        ticks(1);
        irq_is(1'b1, "nest_ch1_irq");
        step(0, 0, 2'd0, 0, 1, 0, 0);
        irq_is(1'b0, "nest_ack1_irq");
        rchk(2'd2, 32'h22, "nest_inserv22");
        rchk(2'd3, 32'h80000001, "nest_vec1");
        step(0, 0, 2'd0, 0, 0, 1, 0);
        rchk(2'd2, 32'h20, "nest_inserv20");
        rchk(2'd3, 32'h80000005, "nest_vec5");
        irq_is(1'b0, "nest_ch6_still_blocked");
        step(0, 0, 2'd0, 0, 0, 1, 0);
        irq_is(1'b0, "nest_rti5_irq");
        ticks(1);
        irq_is(1'b1, "nest_ch6_irq");
        step(0, 0, 2'd0, 0, 1, 0, 0);
        step(0, 0, 2'd0, 0, 0, 1, 0);
        irq_in = 8'h00;

        // Level channel 0: irq drops for exactly one cycle after rti, W1C ignored.
        irq_in = 8'h01;
        ticks(3);
        irq_is(1'b0, "lvl_latency");
        ticks(1);
        irq_is(1'b1, "lvl_irq");
        step(0, 0, 2'd0, 0, 1, 0, 0);
        irq_is(1'b0, "lvl_ack_irq");
        ticks(1);
        irq_is(1'b0, "lvl_inserv_irq");
        wreg(2'd2, 32'h01);
        rchk(2'd1, 32'h01, "lvl_w1c_noeffect");
        step(0, 0, 2'd0, 0, 0, 1, 0);
        irq_is(1'b0, "lvl_rti_low");
        ticks(1);
        irq_is(1'b1, "lvl_reassert");
        irq_in = 8'h00;
        ticks(4);
        irq_is(1'b0, "lvl_release");

        // Races: stray ack, same-cycle rti+ack, abort.
        step(0, 0, 2'd0, 0, 1, 0, 0);
        rchk(2'd2, 32'h00, "race_stray_ack_inserv");
        rchk(2'd1, 32'h00, "race_stray_ack_pend");
        wreg(2'd1, 32'h04);
        step(0, 0, 2'd0, 0, 1, 0, 0);
        wreg(2'd1, 32'h08);
        step(0, 0, 2'd0, 0, 1, 1, 0);
        irq_is(1'b0, "race_rti_ack_irq");
        rchk(2'd2, 32'h08, "race_rti_ack_inserv");
        rchk(2'd1, 32'h00, "race_rti_ack_pend");
        wreg(2'd1, 32'h04);
        step(0, 0, 2'd0, 0, 1, 0, 0);
        rchk(2'd2, 32'h0C, "race_inserv0c");
        wreg(2'd1, 32'h40);
        step(0, 0, 2'd0, 0, 0, 0, 1);
        rchk(2'd2, 32'h00, "race_abort_inserv");
        rchk(2'd1, 32'h40, "race_abort_pend");
        step(0, 0, 2'd0, 0, 1, 0, 0);
        step(0, 0, 2'd0, 0, 0, 1, 0);

        // Asynchronous reset mid-ISR with inserv=0x05.
        wreg(2'd1, 32'h04);
        step(0, 0, 2'd0, 0, 1, 0, 0);
        irq_in = 8'h01;
        ticks(4);
        step(0, 0, 2'd0, 0, 1, 0, 0);
        rchk(2'd2, 32'h05, "rst_pre_inserv");
        #2 rst = 1;
        irq_in = 8'h00;
        #1;
        irq_is(1'b0, "rst_async_irq");
        check("rst_async_dout", dout, 32'd0);
        for (int i = 0; i < 2; i++) begin
            ticks(1);
            irq_is(1'b0, "rst_held_irq");
            check("rst_held_dout", dout, 32'd0);
        end
        rst = 0;
        for (int a = 0; a < 4; a++) rchk(2'(a), 32'd0, $sformatf("rst_reg%0d", a));

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 2) == 0) irq_in[$urandom_range(0, 7)] ^= 1'b1;
            step(($urandom_range(0, 5) == 0), $urandom_range(0, 1) == 1,
                 2'($urandom_range(0, 3)), $urandom & $urandom,
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 6) == 0),
                 ($urandom_range(0, 40) == 0));
        end

        mon_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
